// File: rtl/mul_share_arbiter_if.sv
// Two-requester operand bus plus the shared result channel of mul_share_arbiter.
// slave is the arbiter side; master is the requester/consumer side.
interface mul_share_arbiter_if;
  logic       req0_valid;
  logic [3:0] req0_a;
  logic [3:0] req0_b;
  logic       req0_ready;
  logic       req1_valid;
  logic [3:0] req1_a;
  logic [3:0] req1_b;
  logic       req1_ready;
  logic       rsp_valid;
  logic [7:0] rsp_prod;
  logic       rsp_id;
  logic       rsp_ready;

  modport slave (
    input  req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, rsp_ready,
    output req0_ready, req1_ready, rsp_valid, rsp_prod, rsp_id
  );

  modport master (
    output req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, rsp_ready,
    input  req0_ready, req1_ready, rsp_valid, rsp_prod, rsp_id
  );
endinterface

// File: rtl/mul_share_arbiter.sv
// One 4x4 array multiplier shared by two requesters: round-robin grant in IDLE,
// a fixed CALC_CYCLES settle window, then the product is held until consumed.
module ARRAY_MUL (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] mul
);
  logic [4:0][7:0] acc;

  assign acc[0] = '0;
  for (genvar i = 0; i < 4; i++) begin : g_row
    assign acc[i+1] = acc[i] + ({8{b[i]}} & (8'(a) << i));
  end
  assign mul = acc[4];
endmodule

module mul_share_arbiter #(
  parameter int CALC_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst,
  mul_share_arbiter_if.slave bus,
  output logic               busy
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  localparam logic [3:0] CNT_INIT = 4'(CALC_CYCLES - 1);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] a_q, a_d, b_q, b_d;
  logic       id_q, id_d;
  logic       last_q, last_d;
  logic       rid_q, rid_d;
  logic [7:0] prod_q, prod_d;
  logic [7:0] mul;
  logic       any_v, gnt1, idle;

  ARRAY_MUL u_mul (.a(a_q), .b(b_q), .mul(mul));

  // A tie goes to whoever did not win last; a lone requester always wins.
  assign any_v = bus.req0_valid | bus.req1_valid;
  assign gnt1  = bus.req1_valid & (~bus.req0_valid | ~last_q);
  assign idle  = (state_q == IDLE) & ~rst;

  assign bus.req0_ready = idle & bus.req0_valid & ~gnt1;
  assign bus.req1_ready = idle & gnt1;
  assign bus.rsp_valid  = (state_q == DONE);
  assign bus.rsp_prod   = prod_q;
  assign bus.rsp_id     = rid_q;
  assign busy           = (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    id_d    = id_q;
    last_d  = last_q;
    rid_d   = rid_q;
    prod_d  = prod_q;
    case (state_q)
      IDLE: if (any_v) begin
        a_d     = gnt1 ? bus.req1_a : bus.req0_a;
        b_d     = gnt1 ? bus.req1_b : bus.req0_b;
        id_d    = gnt1;
        last_d  = gnt1;
        cnt_d   = CNT_INIT;
        state_d = CALC;
      end
      CALC: if (cnt_q == 4'd0) begin
        prod_d  = mul;
        rid_d   = id_q;
        state_d = DONE;
      end else begin
        cnt_d   = cnt_q - 4'd1;
      end
      DONE: if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      id_q    <= 1'b0;
      last_q  <= 1'b1;
      rid_q   <= 1'b0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      id_q    <= id_d;
      last_q  <= last_d;
      rid_q   <= rid_d;
      prod_q  <= prod_d;
    end
  end
endmodule

// File: tb/tb_mul_share_arbiter.sv
// Scoreboard bench for mul_share_arbiter: drivers feed per-requester operand queues,
// a monitor checks every presented result against the expected-response queue.
module tb_mul_share_arbiter;
  localparam int CC = 2;

  typedef struct { logic id; logic [7:0] prod; } exp_t;
  typedef struct { logic [3:0] a; logic [3:0] b; } op_t;

  logic clk = 1'b0;
  logic rst;
  logic busy, busy1, busy15;
  int   total = 0, bad = 0, cyc = 0;
  exp_t expq[$];
  int   accq[$];
  op_t  q0[$], q1[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mul_share_arbiter_if bus ();
  mul_share_arbiter_if b1 ();
  mul_share_arbiter_if b15 ();

  mul_share_arbiter #(.CALC_CYCLES(CC)) u_dut (.clk(clk), .rst(rst), .bus(bus), .busy(busy));
  mul_share_arbiter #(.CALC_CYCLES(1))  u_d1  (.clk(clk), .rst(rst), .bus(b1),  .busy(busy1));
  mul_share_arbiter #(.CALC_CYCLES(15)) u_d15 (.clk(clk), .rst(rst), .bus(b15), .busy(busy15));

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%h want=%h (cyc %0d)", nm, got, want, cyc);
    end
  endtask

  task automatic fail(input string nm);
    total++;
    bad++;
    $display("FAIL %s (cyc %0d)", nm, cyc);
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    q0.delete(); q1.delete(); expq.delete(); accq.delete();
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic drain(input string nm);
    int n = 0;
    while ((q0.size() != 0 || q1.size() != 0 || expq.size() != 0 || busy) && n < 300) begin
      tick();
      n++;
    end
    if (n >= 300) fail({nm, "_timeout"});
  endtask

  // Requester drivers: hold the queue head until it is seen accepted.
  initial begin
    bit p0 = 0, p1 = 0;
    bus.req0_valid = 0; bus.req0_a = 0; bus.req0_b = 0;
    bus.req1_valid = 0; bus.req1_a = 0; bus.req1_b = 0;
    forever begin
      @(negedge clk);
      if (p0 && q0.size() != 0) void'(q0.pop_front());
      if (p1 && q1.size() != 0) void'(q1.pop_front());
      bus.req0_valid = (q0.size() != 0);
      bus.req1_valid = (q1.size() != 0);
      if (q0.size() != 0) begin bus.req0_a = q0[0].a; bus.req0_b = q0[0].b; end
      if (q1.size() != 0) begin bus.req1_a = q1[0].a; bus.req1_b = q1[0].b; end
      #2;
      p0 = bus.req0_valid && bus.req0_ready && !rst;
      p1 = bus.req1_valid && bus.req1_ready && !rst;
      if (p0 || p1) accq.push_back(cyc + 1);
    end
  end

  // Monitor: latency on each new result, contents and hold every valid cycle.
  initial begin
    bit pv = 0;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        chk("rst_ready0", bus.req0_ready, 0);
        chk("rst_ready1", bus.req1_ready, 0);
        pv = 0;
      end else begin
        if (bus.rsp_valid) begin
          if (expq.size() == 0) begin
            fail("unexpected_rsp");
          end else begin
            if (!pv) begin
              if (accq.size() != 0) chk("latency", cyc - accq.pop_front(), CC);
              else fail("rsp_without_accept");
            end
            chk("rsp_id", bus.rsp_id, expq[0].id);
            chk("rsp_prod", bus.rsp_prod, expq[0].prod);
            chk("busy_done", busy, 1);
            chk("ready_done", {bus.req0_ready, bus.req1_ready}, 0);
            if (bus.rsp_ready) void'(expq.pop_front());
          end
        end
        pv = bus.rsp_valid;
      end
    end
  end

  initial begin
    int n, t0, l1, l15;
    rst = 1'b1;
    bus.rsp_ready = 1'b1;
    b1.req0_valid = 0;  b1.req0_a = 0;  b1.req0_b = 0;  b1.req1_valid = 0;  b1.req1_a = 0;  b1.req1_b = 0;
    b15.req0_valid = 0; b15.req0_a = 0; b15.req0_b = 0; b15.req1_valid = 0; b15.req1_a = 0; b15.req1_b = 0;
    b1.rsp_ready = 1'b1; b15.rsp_ready = 1'b1;
    tick(); tick();
    chk("reset_rsp_valid", bus.rsp_valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_prod", bus.rsp_prod, 0);
    chk("reset_id", bus.rsp_id, 0);
    rst = 1'b0;
    tick();

    q0.push_back('{4'h3, 4'h4}); expq.push_back('{1'b0, 8'h0C});
    drain("single");

    do_reset();
    q0.push_back('{4'hB, 4'hB}); q1.push_back('{4'hF, 4'hD});
    expq.push_back('{1'b0, 8'h79}); expq.push_back('{1'b1, 8'hC3});
    drain("tie");

    do_reset();
    q0.push_back('{4'h1, 4'h2}); q0.push_back('{4'h2, 4'h3});
    q1.push_back('{4'h4, 4'h5}); q1.push_back('{4'h6, 4'h7});
    expq.push_back('{1'b0, 8'h02}); expq.push_back('{1'b1, 8'h14});
    expq.push_back('{1'b0, 8'h06}); expq.push_back('{1'b1, 8'h2A});
    drain("round_robin");

    bus.rsp_ready = 1'b0;
    q0.push_back('{4'h5, 4'h6}); q1.push_back('{4'h2, 4'h2});
    expq.push_back('{1'b0, 8'h1E}); expq.push_back('{1'b1, 8'h04});
    n = 0;
    while (!bus.rsp_valid && n < 20) begin tick(); n++; end
    if (n >= 20) fail("backpressure_timeout");
    repeat (5) tick();
    bus.rsp_ready = 1'b1;
    drain("backpressure");

    q0.push_back('{4'h0, 4'hF}); q0.push_back('{4'hF, 4'hF});
    expq.push_back('{1'b0, 8'h00}); expq.push_back('{1'b0, 8'hE1});
    drain("boundary");

    q0.push_back('{4'h7, 4'h7});
    n = 0;
    while (!busy && n < 20) begin tick(); n++; end
    if (n >= 20) fail("midcalc_timeout");
    rst = 1'b1;
    q0.delete(); q1.delete(); expq.delete(); accq.delete();
    tick();
    chk("midcalc_rsp_valid", bus.rsp_valid, 0);
    chk("midcalc_busy", busy, 0);
    rst = 1'b0;
    repeat (6) tick();
    q0.push_back('{4'h2, 4'h5}); q1.push_back('{4'h3, 4'h3});
    expq.push_back('{1'b0, 8'h0A}); expq.push_back('{1'b1, 8'h09});
    drain("post_reset_tie");

    // Latency extremes on the CALC_CYCLES=1 and =15 instances.
    b1.req0_a = 4'h0;  b1.req0_b = 4'hF;  b1.req0_valid = 1'b1;
    b15.req0_a = 4'hF; b15.req0_b = 4'hF; b15.req0_valid = 1'b1;
    #1;
    chk("c1_ready", b1.req0_ready, 1);
    chk("c15_ready", b15.req0_ready, 1);
    t0 = cyc + 1;
    l1 = -1; l15 = -1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (i == 0) begin b1.req0_valid = 1'b0; b15.req0_valid = 1'b0; end
      if (b1.rsp_valid && l1 < 0) begin l1 = cyc - t0; chk("c1_prod", b1.rsp_prod, 8'h00); end
      if (b15.rsp_valid && l15 < 0) begin l15 = cyc - t0; chk("c15_prod", b15.rsp_prod, 8'hE1); end
    end
    chk("c1_latency", l1, 1);
    chk("c15_latency", l15, 15);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
